// File: rtl/mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mem_ctrl
// Brief    : Arbitrates instruction fetch, load and store requests onto a
//            byte-wide synchronous RAM port; multi-byte accesses are split
//            into consecutive little-endian byte cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instruction_read_flag,
  input  logic [31:0] instruction_read_address_in,
  output logic        instruction_flag,
  output logic [31:0] instruction_read_address,
  output logic [31:0] instruction,
  input  logic        data_read_flag,
  input  logic        data_write_flag,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_write_data,
  output logic        data_flag,
  output logic [31:0] data_read_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {T_FETCH, T_LOAD, T_STORE} req_t;

  state_t      r_state, w_state;
  req_t        r_type, w_type;
  logic [31:0] r_addr, w_addr;
  logic [2:0]  r_n, w_n;
  logic [2:0]  r_cnt, w_cnt;
  logic [31:0] r_wdata, w_wdata;
  logic [31:0] r_buf, w_buf;

  logic [31:0] w_mem_a;
  logic [7:0]  w_mem_dout;
  logic        w_mem_wr;
  logic        w_iflag, w_dflag;
  logic [31:0] w_instr, w_iaddr, w_rdata;
  logic [2:0]  w_cnt_inc;
  logic [1:0]  w_byte_idx;

  // Byte count of a data access; width code 3 is treated as a word.
  function automatic logic [2:0] f_width_n(input logic [1:0] w);
    case (w)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign w_cnt_inc  = r_cnt + 3'd1;
  // In READ, the byte arriving now was addressed one cycle earlier.
  assign w_byte_idx = r_cnt[1:0] - 2'd1;

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    w_state    = r_state;
    w_type     = r_type;
    w_addr     = r_addr;
    w_n        = r_n;
    w_cnt      = r_cnt;
    w_wdata    = r_wdata;
    w_buf      = r_buf;
    w_mem_a    = mem_a;
    w_mem_dout = mem_dout;
    w_mem_wr   = 1'b0;
    w_iflag    = 1'b0;
    w_dflag    = 1'b0;
    w_instr    = instruction;
    w_iaddr    = instruction_read_address;
    w_rdata    = data_read_data;
    case (r_state)
      S_IDLE: begin
        w_cnt = 3'd0;
        w_buf = 32'd0;
        if (data_write_flag) begin
          // Store wins, including when a load is requested at the same time.
          w_type     = T_STORE;
          w_addr     = data_address;
          w_n        = f_width_n(data_width);
          w_wdata    = data_write_data >> 8;
          w_mem_a    = data_address;
          w_mem_dout = data_write_data[7:0];
          w_mem_wr   = 1'b1;
          w_state    = S_WRITE;
        end else if (data_read_flag) begin
          w_type  = T_LOAD;
          w_addr  = data_address;
          w_n     = f_width_n(data_width);
          w_mem_a = data_address;
          w_state = S_READ;
        end else if (instruction_read_flag) begin
          w_type  = T_FETCH;
          w_addr  = instruction_read_address_in;
          w_n     = 3'd4;
          w_mem_a = instruction_read_address_in;
          w_state = S_READ;
        end
      end
      S_READ: begin
        w_cnt = w_cnt_inc;
        if (w_cnt_inc < r_n) begin
          w_mem_a = mem_a + 32'd1;
        end
        if (r_cnt != 3'd0) begin
          w_buf[{w_byte_idx, 3'b000} +: 8] = mem_din;
        end
        if (r_cnt == r_n) begin
          w_state = S_DONE;
          if (r_type == T_FETCH) begin
            w_iflag = 1'b1;
            w_instr = w_buf;
            w_iaddr = r_addr;
          end else begin
            w_dflag = 1'b1;
            w_rdata = w_buf;
          end
        end
      end
      S_WRITE: begin
        w_cnt = w_cnt_inc;
        if (w_cnt_inc < r_n) begin
          w_mem_a    = mem_a + 32'd1;
          w_mem_dout = r_wdata[7:0];
          w_wdata    = r_wdata >> 8;
          w_mem_wr   = 1'b1;
        end else begin
          w_state = S_DONE;
          w_dflag = 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                  <= S_IDLE;
      r_type                   <= T_FETCH;
      r_addr                   <= 32'd0;
      r_n                      <= 3'd0;
      r_cnt                    <= 3'd0;
      r_wdata                  <= 32'd0;
      r_buf                    <= 32'd0;
      mem_a                    <= 32'd0;
      mem_dout                 <= 8'd0;
      mem_wr                   <= 1'b0;
      instruction_flag         <= 1'b0;
      data_flag                <= 1'b0;
      instruction              <= 32'd0;
      instruction_read_address <= 32'd0;
      data_read_data           <= 32'd0;
    end else begin
      r_state                  <= w_state;
      r_type                   <= w_type;
      r_addr                   <= w_addr;
      r_n                      <= w_n;
      r_cnt                    <= w_cnt;
      r_wdata                  <= w_wdata;
      r_buf                    <= w_buf;
      mem_a                    <= w_mem_a;
      mem_dout                 <= w_mem_dout;
      mem_wr                   <= w_mem_wr;
      instruction_flag         <= w_iflag;
      data_flag                <= w_dflag;
      instruction              <= w_instr;
      instruction_read_address <= w_iaddr;
      data_read_data           <= w_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl with a byte RAM model and a
//            transaction-level reference memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instruction_read_flag;
  logic [31:0] instruction_read_address_in;
  logic        instruction_flag;
  logic [31:0] instruction_read_address;
  logic [31:0] instruction;
  logic        data_read_flag;
  logic        data_write_flag;
  logic [31:0] data_address;
  logic [1:0]  data_width;
  logic [31:0] data_write_data;
  logic        data_flag;
  logic [31:0] data_read_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  ram   [logic [31:0]];
  logic [7:0]  ref_m [logic [31:0]];
  logic [31:0] last_instr = 32'd0;
  logic [31:0] last_iaddr = 32'd0;
  logic [31:0] last_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk                         (clk),
    .rst                         (rst),
    .instruction_read_flag       (instruction_read_flag),
    .instruction_read_address_in (instruction_read_address_in),
    .instruction_flag            (instruction_flag),
    .instruction_read_address    (instruction_read_address),
    .instruction                 (instruction),
    .data_read_flag              (data_read_flag),
    .data_write_flag             (data_write_flag),
    .data_address                (data_address),
    .data_width                  (data_width),
    .data_write_data             (data_write_data),
    .data_flag                   (data_flag),
    .data_read_data              (data_read_data),
    .mem_din                     (mem_din),
    .mem_dout                    (mem_dout),
    .mem_a                       (mem_a),
    .mem_wr                      (mem_wr)
  );

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : dflt(a);
  endfunction

  // RAM: samples the address at the edge, read byte appears after it.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The two completion pulses must never coincide.
  always @(negedge clk) begin
    if (!rst) chk("no_overlap", {31'd0, instruction_flag & data_flag}, 32'd0);
  end

  function automatic int nbytes(input int typ, input logic [1:0] w);
    if (typ == 0) return 4;
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  // One transaction: typ 0 fetch, 1 load, 2 store. Starts #1 after an edge
  // with the DUT idle; ends #1 after the edge that leaves the done cycle.
  task automatic txn(input int typ, input logic [31:0] a, input logic [1:0] w,
                     input logic [31:0] wd, input bit hold_f);
    int          n;
    logic [31:0] exp;
    n   = nbytes(typ, w);
    exp = 32'd0;
    for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_rd(a + i);
    data_write_flag       = (typ == 2);
    data_read_flag        = (typ == 1) || (typ == 2 && $urandom_range(0, 1) == 1);
    instruction_read_flag = (typ == 0) || hold_f;
    if (typ == 0) instruction_read_address_in = a;
    else          data_address = a;
    data_width      = w;
    data_write_data = wd;
    @(posedge clk); #1;
    // Accepted; scramble the inputs to show they were latched.
    data_write_flag = 1'b0;
    data_read_flag  = 1'b0;
    if (!hold_f) instruction_read_flag = 1'b0;
    data_address    = $urandom;
    data_width      = 2'($urandom_range(0, 3));
    data_write_data = $urandom;
    if (!hold_f) instruction_read_address_in = $urandom;
    if (typ == 2) begin
      for (int k = 0; k < n; k++) begin
        chk("wr_addr", mem_a, a + k);
        chk("wr_en", {31'd0, mem_wr}, 32'd1);
        chk("wr_byte", {24'd0, mem_dout}, {24'd0, wd[8*k +: 8]});
        chk("wr_flag_early", {31'd0, data_flag}, 32'd0);
        ref_m[a + k] = wd[8*k +: 8];
        @(posedge clk); #1;
      end
      chk("wr_done_flag", {31'd0, data_flag}, 32'd1);
      chk("wr_done_en", {31'd0, mem_wr}, 32'd0);
      chk("wr_done_iflag", {31'd0, instruction_flag}, 32'd0);
      chk("wr_instr_hold", instruction, last_instr);
    end else begin
      for (int k = 0; k < n; k++) begin
        chk("rd_addr", mem_a, a + k);
        chk("rd_en", {31'd0, mem_wr}, 32'd0);
        chk("rd_flags_early", {30'd0, instruction_flag, data_flag}, 32'd0);
        @(posedge clk); #1;
      end
      chk("rd_flags_late", {30'd0, instruction_flag, data_flag}, 32'd0);
      @(posedge clk); #1;
      if (typ == 0) begin
        chk("fetch_flag", {30'd0, instruction_flag, data_flag}, 32'd2);
        chk("fetch_word", instruction, exp);
        chk("fetch_addr", instruction_read_address, a);
        chk("fetch_rdata_hold", data_read_data, last_rdata);
        last_instr = exp;
        last_iaddr = a;
        if (!hold_f) instruction_read_flag = 1'b0;
      end else begin
        chk("load_flag", {30'd0, instruction_flag, data_flag}, 32'd1);
        chk("load_data", data_read_data, exp);
        chk("load_instr_hold", instruction, last_instr);
        chk("load_iaddr_hold", instruction_read_address, last_iaddr);
        last_rdata = exp;
      end
    end
    @(posedge clk); #1;
    chk("pulse_len", {30'd0, instruction_flag, data_flag}, 32'd0);
  endtask

  initial begin
    rst                         = 1'b1;
    instruction_read_flag       = 1'b0;
    instruction_read_address_in = 32'd0;
    data_read_flag              = 1'b0;
    data_write_flag             = 1'b0;
    data_address                = 32'd0;
    data_width                  = 2'd0;
    data_write_data             = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_flags", {30'd0, instruction_flag, data_flag}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_iaddr", instruction_read_address, 32'd0);
    chk("rst_rdata", data_read_data, 32'd0);
    rst = 1'b0;

    // Directed fetch of a known instruction word.
    ram[32'h1004] = 8'h13; ram[32'h1005] = 8'h00; ram[32'h1006] = 8'hA0; ram[32'h1007] = 8'hE3;
    ref_m[32'h1004] = 8'h13; ref_m[32'h1005] = 8'h00; ref_m[32'h1006] = 8'hA0; ref_m[32'h1007] = 8'hE3;
    txn(0, 32'h0000_1004, 2'd2, 32'd0, 1'b0);
    chk("fetch_const", instruction, 32'hE3A0_0013);

    // Word store, then read it back.
    txn(2, 32'h0000_0200, 2'd2, 32'hDEAD_BEEF, 1'b0);
    txn(1, 32'h0000_0200, 2'd2, 32'd0, 1'b0);
    chk("store_readback", data_read_data, 32'hDEAD_BEEF);

    // Byte load.
    ram[32'h301] = 8'h9C; ref_m[32'h301] = 8'h9C;
    txn(1, 32'h0000_0301, 2'd0, 32'd0, 1'b0);
    chk("load_byte_const", data_read_data, 32'h0000_009C);

    // Half-word load wrapping the address space.
    txn(1, 32'hFFFF_FFFF, 2'd1, 32'd0, 1'b0);

    // Store and fetch together: store first, then the held fetch once.
    instruction_read_address_in = 32'h0000_1004;
    txn(2, 32'h0000_0210, 2'd2, 32'h1122_3344, 1'b1);
    txn(0, 32'h0000_1004, 2'd2, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("no_refetch", {31'd0, instruction_flag}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset during the third byte of a word store with a fetch held.
    instruction_read_address_in = 32'h0000_1004;
    instruction_read_flag       = 1'b1;
    data_write_flag             = 1'b1;
    data_address                = 32'h0000_4000;
    data_width                  = 2'd2;
    data_write_data             = $urandom;
    @(posedge clk); #1;
    data_write_flag = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_addr", mem_a, 32'h0000_4002);
    chk("abort_pre_wr", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_wr", {31'd0, mem_wr}, 32'd0);
    chk("abort_flags", {30'd0, instruction_flag, data_flag}, 32'd0);
    chk("abort_mem_a", mem_a, 32'd0);
    chk("abort_instr", instruction, 32'd0);
    chk("abort_rdata", data_read_data, 32'd0);
    last_instr = 32'd0;
    last_iaddr = 32'd0;
    last_rdata = 32'd0;
    txn(0, 32'h0000_1004, 2'd2, 32'd0, 1'b0);

    // Random mix in a small window so loads see earlier stores.
    for (int t = 0; t < 40; t++) begin
      txn($urandom_range(0, 2), 32'h0000_0800 + $urandom_range(0, 60),
          2'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
